// File: rtl/pic_bus_master.sv
// CPU-side initiator for the 8259 register port: expands one command into a short
// queue of CS/WR/RD/A0 bus cycles and reports completion with a one-cycle response.
module pic_bus_master #(
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       initialized,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       A0,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  localparam int MAXC  = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {RSEL_NONE, RSEL_IRR, RSEL_ISR} rsel_t;

  state_t            state, state_n;
  rsel_t             last_rsel, dec_rsel;
  logic              q_wr   [4];
  logic              q_a0   [4];
  logic [7:0]        q_byte [4];
  logic              d_wr   [4];
  logic              d_a0   [4];
  logic [7:0]        d_byte [4];
  logic [2:0]        q_len, d_len;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;
  logic              err_q, init_q, d_err;
  logic [7:0]        rd_data;
  logic              accept, in_cycle, cur_wr, cur_a0, last_entry;
  logic [7:0]        cur_byte;

  assign accept     = cmd_valid & cmd_ready;
  assign cur_wr     = q_wr[idx];
  assign cur_a0     = q_a0[idx];
  assign cur_byte   = q_byte[idx];
  assign last_entry = ({1'b0, idx} == (q_len - 3'd1));

  // Command decode: build the bus-cycle queue and the read-select bookkeeping.
  always_comb begin
    rsel_t want;
    d_err    = 1'b0;
    d_len    = 3'd0;
    dec_rsel = last_rsel;
    want     = RSEL_NONE;
    for (int i = 0; i < 4; i++) begin
      d_wr[i]   = 1'b0;
      d_a0[i]   = 1'b0;
      d_byte[i] = 8'h00;
    end
    case (cmd_op)
      2'b00: begin
        if (!icw1[4]) begin
          d_err = 1'b1;
        end else begin
          d_wr[0] = 1'b1; d_a0[0] = 1'b0; d_byte[0] = icw1;
          d_wr[1] = 1'b1; d_a0[1] = 1'b1; d_byte[1] = icw2;
          d_len   = 3'd2;
          if (!icw1[1]) begin
            d_wr[d_len[1:0]] = 1'b1; d_a0[d_len[1:0]] = 1'b1; d_byte[d_len[1:0]] = icw3;
            d_len = d_len + 3'd1;
          end
          if (icw1[0]) begin
            d_wr[d_len[1:0]] = 1'b1; d_a0[d_len[1:0]] = 1'b1; d_byte[d_len[1:0]] = icw4;
            d_len = d_len + 3'd1;
          end
          dec_rsel = RSEL_NONE;
        end
      end
      2'b01: begin
        if (!initialized || (!cmd_a0 && cmd_data[4])) begin
          d_err = 1'b1;
        end else begin
          d_wr[0] = 1'b1; d_a0[0] = cmd_a0; d_byte[0] = cmd_data;
          d_len   = 3'd1;
          // A direct OCW3 with RR set changes which register a plain read returns.
          if (!cmd_a0 && (cmd_data[4:3] == 2'b01) && cmd_data[1])
            dec_rsel = cmd_data[0] ? RSEL_ISR : RSEL_IRR;
        end
      end
      2'b10: begin
        if (cmd_data[1:0] == 2'b00) begin
          d_err = 1'b1;
        end else if (cmd_data[1:0] == 2'b11) begin
          d_a0[0] = 1'b1;
          d_len   = 3'd1;
        end else begin
          want = (cmd_data[1:0] == 2'b01) ? RSEL_IRR : RSEL_ISR;
          if (last_rsel != want) begin
            d_wr[0] = 1'b1; d_a0[0] = 1'b0;
            d_byte[0] = (want == RSEL_IRR) ? 8'h0A : 8'h0B;
            d_len = 3'd1;
          end
          d_a0[d_len[1:0]] = 1'b0;
          d_len    = d_len + 3'd1;
          dec_rsel = want;
        end
      end
      default: d_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 2'd0;
      q_len       <= 3'd0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
      initialized <= 1'b0;
      last_rsel   <= RSEL_NONE;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        idx    <= 2'd0;
        q_len  <= d_len;
        err_q  <= d_err;
        init_q <= (cmd_op == 2'b00);
        if (!d_err) begin
          last_rsel <= dec_rsel;
          if (cmd_op == 2'b00) initialized <= 1'b0;
        end
      end else if (state == S_GAP) begin
        idx <= idx + 2'd1;
      end
      if (state == S_DONE && init_q && !err_q) initialized <= 1'b1;
    end
  end

  // Queue contents and captured read data carry no reset; outputs gate them by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        q_wr[i]   <= d_wr[i];
        q_a0[i]   <= d_a0[i];
        q_byte[i] <= d_byte[i];
      end
    end
    if (state == S_STROBE && cnt == CNT_W'(STROBE_CYCLES - 1) && !cur_wr)
      rd_data <= bus_din;
  end

  always_comb begin
    state_n   = state;
    in_cycle  = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    cmd_ready = (state == S_IDLE) && !rst;
    CS        = !in_cycle;
    WR        = !((state == S_STROBE) && cur_wr);
    RD        = !((state == S_STROBE) && !cur_wr);
    A0        = in_cycle && cur_a0;
    bus_oe    = in_cycle && cur_wr;
    bus_dout  = (in_cycle && cur_wr) ? cur_byte : 8'h00;
    rsp_valid = (state == S_DONE);
    rsp_err   = (state == S_DONE) && err_q;
    rsp_data  = ((state == S_DONE) && !err_q && !cur_wr) ? rd_data : 8'h00;
    case (state)
      S_IDLE:   if (accept) state_n = d_err ? S_DONE : S_SETUP;
      S_SETUP:  state_n = S_STROBE;
      S_STROBE: if (cnt == CNT_W'(STROBE_CYCLES - 1)) state_n = S_HOLD;
      S_HOLD:   if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_n = last_entry ? S_DONE : S_GAP;
      S_GAP:    state_n = S_SETUP;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pic_bus_master.sv
// Bench for pic_bus_master: directed scenarios plus randomized commands checked
// against a transaction-level model of the PIC bus sequence.
module tb_pic_bus_master;

  localparam int SC = 2;
  localparam int HC = 1;

  typedef struct packed {
    logic       wr;
    logic       a0;
    logic [7:0] d;
  } bc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_a0;
  logic [7:0] cmd_data, icw1, icw2, icw3, icw4;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       initialized;
  logic       CS, WR, RD, A0;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] bus_din;

  int         n_cmp = 0;
  int         n_bad = 0;
  bc_t        obs[$];
  bc_t        exp_q[$];
  logic       exp_err;
  logic [7:0] exp_rd;
  logic       init_m;
  int         rsel_m;
  logic       got;
  int         lat;
  logic [7:0] r_data;
  logic       r_err;
  int         viol;
  logic       cs_seen;
  logic [7:0] pic_val = 8'h00;

  // Data only valid while RD is low, so a late capture sees the complement.
  assign bus_din = RD ? ~pic_val : pic_val;

  always #5 clk = ~clk;

  pic_bus_master #(.STROBE_CYCLES(SC), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .initialized(initialized), .CS(CS), .WR(WR), .RD(RD), .A0(A0),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din)
  );

  function automatic bc_t mk(input logic w, input logic a, input logic [7:0] d);
    return {w, a, d};
  endfunction

  function automatic int exp_lat();
    return exp_err ? 1 : exp_q.size() * (2 + SC + HC);
  endfunction

  // Transaction-level reference: what bus cycles a command must produce.
  task automatic model(input logic [1:0] op, input logic a, input logic [7:0] d,
                       input logic [7:0] c1, c2, c3, c4, input logic [7:0] pv);
    exp_q.delete();
    exp_err = 1'b0;
    exp_rd  = 8'h00;
    case (op)
      2'd0: if (!c1[4]) exp_err = 1'b1;
            else begin
              exp_q.push_back(mk(1'b1, 1'b0, c1));
              exp_q.push_back(mk(1'b1, 1'b1, c2));
              if (!c1[1]) exp_q.push_back(mk(1'b1, 1'b1, c3));
              if (c1[0])  exp_q.push_back(mk(1'b1, 1'b1, c4));
              init_m = 1'b1;
              rsel_m = 0;
            end
      2'd1: if (!init_m || (!a && d[4])) exp_err = 1'b1;
            else begin
              exp_q.push_back(mk(1'b1, a, d));
              if (!a && d[4:3] == 2'b01 && d[1]) rsel_m = d[0] ? 2 : 1;
            end
      2'd2: if (d[1:0] == 2'b00) exp_err = 1'b1;
            else if (d[1:0] == 2'b11) begin
              exp_q.push_back(mk(1'b0, 1'b1, 8'h00));
              exp_rd = pv;
            end else begin
              if (rsel_m != int'(d[1:0]))
                exp_q.push_back(mk(1'b1, 1'b0, (d[1:0] == 2'b01) ? 8'h0A : 8'h0B));
              rsel_m = int'(d[1:0]);
              exp_q.push_back(mk(1'b0, 1'b0, 8'h00));
              exp_rd = pv;
            end
      default: exp_err = 1'b1;
    endcase
  endtask

  // Issue one command, record every strobe pulse and any bus-rule violation.
  task automatic do_cmd(input logic [1:0] op, input logic a, input logic [7:0] d,
                        input logic [7:0] c1, c2, c3, c4, input logic [7:0] pv);
    logic pw, pr;
    model(op, a, d, c1, c2, c3, c4, pv);
    obs.delete();
    got = 1'b0; lat = 0; viol = 0; cs_seen = 1'b0; r_data = 8'h00; r_err = 1'b0;
    pic_val = pv;
    for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
    cmd_op = op; cmd_a0 = a; cmd_data = d;
    icw1 = c1; icw2 = c2; icw3 = c3; icw4 = c4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pw = 1'b1; pr = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!WR && !RD) viol++;
      if ((!WR || !RD) && CS) viol++;
      if (!RD && bus_oe) viol++;
      if (!WR && !bus_oe) viol++;
      if (rsp_valid && (!CS || bus_oe)) viol++;
      if (!CS) cs_seen = 1'b1;
      if (!WR && pw) obs.push_back(mk(1'b1, A0, bus_dout));
      else if (!WR && obs.size() > 0 && obs[$] != mk(1'b1, A0, bus_dout)) viol++;
      if (!RD && pr) obs.push_back(mk(1'b0, A0, 8'h00));
      else if (!RD && obs.size() > 0 && obs[$] != mk(1'b0, A0, 8'h00)) viol++;
      pw = WR; pr = RD;
      if (rsp_valid) begin
        got = 1'b1; lat = k; r_data = rsp_data; r_err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a0 = 1'b0; cmd_data = 8'h00;
    icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
    init_m = 1'b0; rsel_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({CS, WR, RD} !== 3'b111) begin
      n_bad++; $display("FAIL reset_strobes got=%b want=111", {CS, WR, RD});
    end
    n_cmp++;
    if ({A0, bus_oe, bus_dout} !== 10'h000) begin
      n_bad++; $display("FAIL reset_bus got=%h want=000", {A0, bus_oe, bus_dout});
    end
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got=%b want=0", cmd_ready);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_data, initialized} !== 11'h000) begin
      n_bad++; $display("FAIL reset_rsp got=%h want=000", {rsp_valid, rsp_err, rsp_data, initialized});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
    end
  endtask

  task automatic test_errors();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] c1s [4] = '{8'h03, 8'h13, 8'h13, 8'h13};
    logic [7:0] ds  [4] = '{8'h00, 8'h20, 8'hFC, 8'h01};
    for (int i = 0; i < 4; i++) begin
      do_cmd(ops[i], 1'b1, ds[i], c1s[i], 8'h20, 8'h00, 8'h01, 8'hA5);
      n_cmp++;
      if (!got || r_err !== 1'b1 || lat != 1) begin
        n_bad++; $display("FAIL err%0d got=%b err=%b lat=%0d want err=1 lat=1", i, got, r_err, lat);
      end
      n_cmp++;
      if (cs_seen !== 1'b0 || r_data !== 8'h00) begin
        n_bad++; $display("FAIL err%0d_bus cs_seen=%b data=%h want 0/00", i, cs_seen, r_data);
      end
      @(negedge clk);
      n_cmp++;
      if (initialized !== 1'b0) begin
        n_bad++; $display("FAIL err%0d_init got=%b want=0", i, initialized);
      end
    end
  endtask

  task automatic test_init_no_icw3();
    do_cmd(2'b00, 1'b0, 8'h00, 8'h13, 8'h20, 8'hEE, 8'h01, 8'h00);
    n_cmp++;
    if (!got || r_err !== 1'b0 || lat != 15) begin
      n_bad++; $display("FAIL init3 got=%b err=%b lat=%0d want err=0 lat=15", got, r_err, lat);
    end
    n_cmp++;
    if (obs.size() != 3 || obs[0] != mk(1'b1, 1'b0, 8'h13) || obs[1] != mk(1'b1, 1'b1, 8'h20)
        || obs[2] != mk(1'b1, 1'b1, 8'h01)) begin
      n_bad++; $display("FAIL init3_bus got=%0d cycles want=3 (013,120,101)", obs.size());
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++; $display("FAIL init3_rules got=%0d violations want=0", viol);
    end
    @(negedge clk);
    n_cmp++;
    if (initialized !== 1'b1) begin
      n_bad++; $display("FAIL init3_init got=%b want=1", initialized);
    end
  endtask

  task automatic test_init_full();
    do_cmd(2'b00, 1'b0, 8'h00, 8'h11, 8'h08, 8'h04, 8'h01, 8'h00);
    n_cmp++;
    if (!got || r_err !== 1'b0 || lat != 20) begin
      n_bad++; $display("FAIL init4 got=%b err=%b lat=%0d want err=0 lat=20", got, r_err, lat);
    end
    n_cmp++;
    if (obs.size() != 4 || obs[0] != mk(1'b1, 1'b0, 8'h11) || obs[1] != mk(1'b1, 1'b1, 8'h08)
        || obs[2] != mk(1'b1, 1'b1, 8'h04) || obs[3] != mk(1'b1, 1'b1, 8'h01)) begin
      n_bad++; $display("FAIL init4_bus got=%0d cycles want=4 (011,108,104,101)", obs.size());
    end
    @(negedge clk);
    n_cmp++;
    if (initialized !== 1'b1) begin
      n_bad++; $display("FAIL init4_init got=%b want=1", initialized);
    end
  endtask

  task automatic test_read_irr_twice();
    do_cmd(2'b10, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A);
    n_cmp++;
    if (obs.size() != 2 || obs[0] != mk(1'b1, 1'b0, 8'h0A) || obs[1] != mk(1'b0, 1'b0, 8'h00)) begin
      n_bad++; $display("FAIL irr1_bus got=%0d cycles want=2 (00A write, A0=0 read)", obs.size());
    end
    n_cmp++;
    if (!got || r_data !== 8'h5A || r_err !== 1'b0 || lat != 10) begin
      n_bad++; $display("FAIL irr1_rsp data=%h lat=%0d want 5a lat=10", r_data, lat);
    end
    do_cmd(2'b10, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A);
    n_cmp++;
    if (obs.size() != 1 || obs[0] != mk(1'b0, 1'b0, 8'h00)) begin
      n_bad++; $display("FAIL irr2_bus got=%0d cycles want=1 read", obs.size());
    end
    n_cmp++;
    if (!got || r_data !== 8'h5A || lat != 5) begin
      n_bad++; $display("FAIL irr2_rsp data=%h lat=%0d want 5a lat=5", r_data, lat);
    end
  endtask

  task automatic test_read_imr();
    do_cmd(2'b10, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0);
    n_cmp++;
    if (obs.size() != 1 || obs[0] != mk(1'b0, 1'b1, 8'h00) || r_data !== 8'hF0 || lat != 5) begin
      n_bad++; $display("FAIL imr cycles=%0d data=%h lat=%0d want 1 read A0=1 f0 lat=5", obs.size(), r_data, lat);
    end
    do_cmd(2'b10, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33);
    n_cmp++;
    if (obs.size() != 1 || obs[0] != mk(1'b0, 1'b0, 8'h00) || r_data !== 8'h33) begin
      n_bad++; $display("FAIL irr_after_imr cycles=%0d data=%h want 1 read 33", obs.size(), r_data);
    end
  endtask

  task automatic test_reset_mid();
    logic pw, hit, saw;
    int   nwr;
    for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
    cmd_op = 2'b00; icw1 = 8'h11; icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h01;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pw = 1'b1; hit = 1'b0; nwr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!WR && pw) nwr++;
      pw = WR;
      if (nwr == 2) begin hit = 1'b1; break; end
    end
    n_cmp++;
    if (!hit) begin
      n_bad++; $display("FAIL midrst_reach got=%0d WR pulses want=2", nwr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({WR, CS, bus_oe, rsp_valid, initialized} !== 5'b11000) begin
      n_bad++; $display("FAIL midrst_bus got=%b want=11000", {WR, CS, bus_oe, rsp_valid, initialized});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    init_m = 1'b0; rsel_m = 0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_bad++; $display("FAIL midrst_norsp got=%b want=0", saw);
    end
    do_cmd(2'b00, 1'b0, 8'h00, 8'h11, 8'h08, 8'h04, 8'h01, 8'h00);
    n_cmp++;
    if (!got || r_err !== 1'b0 || lat != 20 || obs.size() != 4) begin
      n_bad++; $display("FAIL reinit err=%b lat=%0d cycles=%0d want 0/20/4", r_err, lat, obs.size());
    end
    @(negedge clk);
    n_cmp++;
    if (initialized !== 1'b1) begin
      n_bad++; $display("FAIL reinit_init got=%b want=1", initialized);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic       a;
    logic [7:0] d, c1, c2, c3, c4, pv;
    int         r;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 1) ? 2'b11 : (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'b10;
      if (n == 0) op = 2'b00;
      a  = 1'($urandom);
      d  = 8'($urandom);
      c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
      pv = 8'($urandom);
      if ($urandom_range(0, 4) != 0) c1[4] = 1'b1;
      if (op == 2'b01 && $urandom_range(0, 1) == 1) begin a = 1'b0; d[4:3] = 2'b01; end
      do_cmd(op, a, d, c1, c2, c3, c4, pv);
      n_cmp++;
      if (!got || r_err !== exp_err || lat != exp_lat()) begin
        n_bad++; $display("FAIL rnd%0d_rsp op=%0d got=%b err=%b lat=%0d want err=%b lat=%0d",
                          n, op, got, r_err, lat, exp_err, exp_lat());
      end
      n_cmp++;
      if (obs.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rnd%0d_len op=%0d got=%0d want=%0d", n, op, obs.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (obs[i] != exp_q[i]) begin
            n_bad++; $display("FAIL rnd%0d_cyc%0d got=%h want=%h", n, i, obs[i], exp_q[i]);
          end
        end
      end
      n_cmp++;
      if (r_data !== exp_rd || viol != 0) begin
        n_bad++; $display("FAIL rnd%0d_data got=%h viol=%0d want=%h viol=0", n, r_data, viol, exp_rd);
      end
      @(negedge clk);
      n_cmp++;
      if (initialized !== init_m) begin
        n_bad++; $display("FAIL rnd%0d_init got=%b want=%b", n, initialized, init_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_errors();
    test_init_no_icw3();
    test_init_full();
    test_read_irr_twice();
    test_read_imr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pic_bus_master.md
# pic_bus_master

CPU-side bus initiator for the 8259 PIC register interface. It converts single-cycle command requests into correctly sequenced CS/WR/RD/A0 bus cycles toward the PIC read/write logic. It writes the ICW1..ICW4 initialization sequence, writes OCW1/OCW2/OCW3, and reads back IRR, ISR and IMR, inserting the OCW3 read-select write automatically. It sits between the system controller/testbench CPU model and the PIC.

## Interface
- STROBE_CYCLES, 2, clocks WR/RD held low per bus cycle (>=1)
- HOLD_CYCLES, 1, clocks CS/A0/data held after strobe release (>=1)

- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
- cmd_op  in  2  00 INIT, 01 WRITE_OCW, 10 READ, 11 illegal
- cmd_a0  in  1  A0 for WRITE_OCW (1 = OCW1)
- cmd_data  in  8  OCW byte (WRITE_OCW); [1:0] read select 01 IRR, 10 ISR, 11 IMR (READ)
- icw1, icw2, icw3, icw4  in  8 each  init bytes, sampled at accept of INIT
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  read data, valid with rsp_valid (0 for writes/errors)
- rsp_err  out  1  command rejected, valid with rsp_valid
- initialized  out  1  a complete INIT has finished
- CS, WR, RD  out  1 each  active-low PIC strobes
- A0  out  1  PIC address line
- bus_dout  out  8  write data; bus_oe  out  1  drive enable
- bus_din  in  8  PIC read data

## Operation
- States: IDLE, SETUP, STROBE, HOLD, GAP, DONE. A command builds a queue of 1-4 bus cycles at accept. Each entry is {write/read, A0, byte}.
- INIT: error if icw1[4]==0. Queue: ICW1 (A0=0), ICW2 (A0=1), ICW3 (A0=1) only if icw1[1]==0 (SNGL=0), ICW4 (A0=1) only if icw1[0]==1 (IC4). Accept clears initialized and sets last_rsel=NONE. DONE sets initialized.
- WRITE_OCW: error if !initialized, or if cmd_a0==0 && cmd_data[4]==1. One write cycle. If cmd_a0==0, cmd_data[4:3]==01 and cmd_data[1]==1, then last_rsel = cmd_data[0] ? ISR : IRR.
- READ: error if select==00. IMR: one read cycle with A0=1; last_rsel unchanged. IRR/ISR: if last_rsel differs, a write of OCW3 (8'h0A for IRR, 8'h0B for ISR, A0=0) comes first and last_rsel is updated. Then one read cycle with A0=0.
- cmd_op==11: error.
- Errors: DONE the cycle after accept. No bus activity, no state change.
- Read data: bus_din is captured on the last STROBE clock, before RD rises. It is presented on rsp_data in DONE.

## Timing
- SETUP (1 clk): CS=0, A0 valid, WR=RD=1; for writes bus_oe=1 and bus_dout valid.
- STROBE (STROBE_CYCLES clks): WR=0 or RD=0. CS, A0 and data remain stable.
- HOLD (HOLD_CYCLES clks): strobes high; CS, A0 and data still held.
- GAP (1 clk, only between queued cycles): CS=1, bus_oe=0.
- Bus cycle length is 1+STROBE_CYCLES+HOLD_CYCLES. With defaults that is 4 clks.
- DONE (1 clk): rsp_valid=1, CS=1, bus_oe=0. cmd_ready returns the next cycle.
- Single write with defaults: accept at t0, SETUP t1, STROBE t2-t3, HOLD t4, DONE t5, cmd_ready high t6.
- cmd_valid is ignored outside IDLE. Inputs are sampled only at accept.
- WR and RD are never low simultaneously. The data bus is never driven during a read cycle.
- Reset values: CS=WR=RD=1, A0=0, bus_dout=0, bus_oe=0, cmd_ready=0 while rst is high (1 the cycle after rst falls), rsp_valid=0, rsp_data=0, rsp_err=0, initialized=0, last_rsel=NONE.
- rst mid-operation: the command is abandoned with no rsp_valid. All strobes go inactive in the cycle after rst is sampled.

## Test plan
- INIT icw1=0x13, icw2=0x20, icw4=0x01 -> three WR pulses: (A0=0, 0x13), (A0=1, 0x20), (A0=1, 0x01). No ICW3. rsp_valid at t15, rsp_err=0, initialized=1 at t16.
- INIT icw1=0x11, icw2=0x08, icw3=0x04, icw4=0x01 -> four WR pulses in order with ICW3=0x04. rsp_valid at t20.
- READ IRR twice with bus_din=0x5A -> first: OCW3 write 0x0A (A0=0), then RD with A0=0, rsp_data=0x5A. Second: RD only, rsp_valid at t5.
- After a read of IRR, READ IMR with bus_din=0xF0 -> single RD with A0=1, rsp_data=0xF0. A following READ IRR issues no OCW3.
- Errors: INIT icw1=0x03, WRITE_OCW before init, READ select 00, cmd_op 11 -> each gives rsp_valid and rsp_err=1 at t1, CS stays 1 throughout, initialized unchanged.
- rst asserted during STROBE of an ICW2 write -> WR=1 and CS=1 the next cycle, no rsp_valid, initialized=0. Re-INIT completes normally.
